// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Constants shared by the elevator controller and its request
//            latch: floor count, floor index width, travel directions,
//            named floor indices and a request popcount helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package elevator_pkg;

   localparam int NUM_FLOORS = 3;
   localparam int FLOOR_W    = 2;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam logic [FLOOR_W-1:0] FLOOR_0 = 2'd0;
   localparam logic [FLOOR_W-1:0] FLOOR_1 = 2'd1;
   localparam logic [FLOOR_W-1:0] FLOOR_2 = 2'd2;

   // Number of set bits in a request vector. With three floors this is 0..3,
   // so two bits are sufficient.
   function automatic logic [1:0] popcount_req(input logic [NUM_FLOORS-1:0] v);
      logic [1:0] sum;
      sum = 2'd0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         sum = sum + 2'(v[i]);
      end
      return sum;
   endfunction

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Purpose  : Two-flop synchroniser followed by a counter-based debouncer for
//            one raw push button. A new level is accepted only after the
//            synchronised input has differed from the stable level for
//            DEBOUNCE_CYCLES consecutive cycles.
// Ports    : clk       in  system clock, rising edge
//            reset_n   in  asynchronous active-low reset
//            btn_async in  raw button level, asynchronous to clk
//            stb       out debounced stable level
//            press     out high for the cycle in which a 0->1 accept happens
//                          (registered state only, no path from btn_async)
// Revision : 1.0  initial release
// ============================================================================
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_async,
   output logic stb,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // The counter only runs while sync2 disagrees with the stable level; any
   // return to agreement restarts it, so short glitches never get accepted.
   assign accept = (sync2 != stb) && (cnt == CNT_LAST);
   assign press  = accept && sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         stb   <= 1'b0;
      end else begin
         sync1 <= btn_async;
         sync2 <= sync1;
         if (sync2 == stb) begin
            cnt <= '0;
         end else if (accept) begin
            stb <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule : button_debouncer
`default_nettype wire

// File: rtl/elevator_request_latch.sv
`default_nettype none
// ============================================================================
// Module   : elevator_request_latch
// Purpose  : Upstream stage of the elevator controller. Debounces the floor
//            call buttons, latches each press as a pending request and
//            clears it when the controller reports the door open at that
//            floor.
// Ports    : clk           in  system clock, rising edge
//            reset_n       in  asynchronous active-low reset
//            btn           in  raw button levels (1 = pressed), asynchronous
//            current_floor in  floor index from the controller
//            door          in  door-open pulse from the controller
//            req           out pending requests, bit i = floor i
//            new_req       out one-cycle pulse per newly latched request
//            pending_count out number of set bits in req
// Revision : 1.0  initial release
// ============================================================================
module elevator_request_latch
   import elevator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_FLOORS-1:0] btn,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  door,
   output logic [NUM_FLOORS-1:0] req,
   output logic [NUM_FLOORS-1:0] new_req,
   output logic [1:0]            pending_count
);

   logic [NUM_FLOORS-1:0] press;
   logic [NUM_FLOORS-1:0] clear;
   // Debounced levels are only needed inside the debouncers; a held button
   // cannot re-latch because no fresh 0->1 accept occurs until it is released.
   logic [NUM_FLOORS-1:0] stable_unused;

   generate
      for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
         button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_debouncer (
            .clk       (clk),
            .reset_n   (reset_n),
            .btn_async (btn[i]),
            .stb       (stable_unused[i]),
            .press     (press[i])
         );
      end
   endgenerate

   // A floor index outside 0..NUM_FLOORS-1 matches no bit and clears nothing.
   always_comb begin
      clear = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         clear[i] = door && (current_floor == FLOOR_W'(i));
      end
   end

   // Clear has priority over a simultaneous set: the passenger at that floor
   // is already being served, so neither req nor new_req rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req     <= '0;
         new_req <= '0;
      end else begin
         req     <= (req | press) & ~clear;
         new_req <= press & ~req & ~clear;
      end
   end

   assign pending_count = popcount_req(req);

endmodule : elevator_request_latch
`default_nettype wire

// File: tb/tb_elevator_request_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_request_latch
// Purpose  : Self-checking bench for elevator_request_latch. A per-cycle
//            vector table covers clean presses and door clears; directed
//            sequences cover asynchronous reset, bounce, set/clear collision,
//            duplicate presses and holding through a clear.
// Revision : 1.0  initial release
// ============================================================================
module tb_elevator_request_latch;

   logic       clk;
   logic       reset_n;
   logic [2:0] btn;
   logic [1:0] current_floor;
   logic       door;
   logic [2:0] req;
   logic [2:0] new_req;
   logic [1:0] pending_count;

   int checks;
   int failures;

   elevator_request_latch #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn           (btn),
      .current_floor (current_floor),
      .door          (door),
      .req           (req),
      .new_req       (new_req),
      .pending_count (pending_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] b;
      logic [1:0] cf;
      logic       d;
      logic [2:0] exp_req;
      logic [2:0] exp_new;
      logic [1:0] exp_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [2:0] b, input logic [1:0] cf, input logic d,
                      input logic [2:0] er, input logic [2:0] en, input logic [1:0] ec);
      vec_t v;
      v.b = b; v.cf = cf; v.d = d; v.exp_req = er; v.exp_new = en; v.exp_cnt = ec;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive inputs away from the edge, let one rising edge happen, then
   // return on the falling edge where outputs are sampled.
   task automatic step(input logic [2:0] b, input logic [1:0] cf, input logic d);
      btn = b; current_floor = cf; door = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic stepc(input string name, input logic [2:0] b, input logic [1:0] cf,
                        input logic d, input logic [2:0] er, input logic [2:0] en,
                        input logic [1:0] ec);
      step(b, cf, d);
      chk({name, "_req"}, 8'(req), 8'(er));
      chk({name, "_new"}, 8'(new_req), 8'(en));
      chk({name, "_cnt"}, 8'(pending_count), 8'(ec));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      btn      = 3'b000;
      current_floor = 2'd0;
      door     = 1'b0;

      // ---------------- power-on reset ----------------
      repeat (3) @(negedge clk);
      chk("por_req", 8'(req), 8'h0);
      chk("por_new", 8'(new_req), 8'h0);
      chk("por_cnt", 8'(pending_count), 8'h0);
      reset_n = 1'b1;

      // ---------------- reset mid-run with all buttons held ----------------
      for (int i = 0; i < 5; i++) stepc("rst_pre", 3'b111, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      stepc("rst_lat", 3'b111, 2'd0, 1'b0, 3'b111, 3'b111, 2'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_req", 8'(req), 8'h0);
      chk("rst_async_new", 8'(new_req), 8'h0);
      chk("rst_async_cnt", 8'(pending_count), 8'h0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) stepc("rst_rel", 3'b111, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      stepc("rst_6th", 3'b111, 2'd0, 1'b0, 3'b111, 3'b111, 2'd3);

      // ---------------- return to idle: release, then clear each floor ----------------
      for (int i = 0; i < 8; i++) step(3'b000, 2'd0, 1'b0);
      step(3'b000, 2'd0, 1'b1);
      step(3'b000, 2'd1, 1'b1);
      step(3'b000, 2'd2, 1'b1);
      step(3'b000, 2'd0, 1'b0);
      chk("idle_req", 8'(req), 8'h0);
      chk("idle_cnt", 8'(pending_count), 8'h0);

      // ---------------- vector table: clean presses and clears ----------------
      add(3'b100, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      for (int i = 0; i < 4; i++) add(3'b100, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      add(3'b100, 2'd0, 1'b0, 3'b100, 3'b100, 2'd1);   // E5: latch floor 2
      add(3'b100, 2'd0, 1'b0, 3'b100, 3'b000, 2'd1);   // pulse lasts one cycle
      for (int i = 0; i < 5; i++) add(3'b101, 2'd0, 1'b0, 3'b100, 3'b000, 2'd1);
      add(3'b101, 2'd0, 1'b0, 3'b101, 3'b001, 2'd2);   // floor 0 latched
      add(3'b101, 2'd0, 1'b0, 3'b101, 3'b000, 2'd2);
      add(3'b000, 2'd2, 1'b1, 3'b001, 3'b000, 2'd1);   // door at floor 2
      add(3'b000, 2'd3, 1'b1, 3'b001, 3'b000, 2'd1);   // floor 3 clears nothing
      add(3'b000, 2'd0, 1'b0, 3'b001, 3'b000, 2'd1);   // door low clears nothing
      add(3'b000, 2'd0, 1'b1, 3'b000, 3'b000, 2'd0);   // door at floor 0
      for (int i = 0; i < 5; i++) add(3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);

      foreach (tbl[k]) begin
         stepc($sformatf("vec%0d", k), tbl[k].b, tbl[k].cf, tbl[k].d,
               tbl[k].exp_req, tbl[k].exp_new, tbl[k].exp_cnt);
      end

      // ---------------- bounce on floor 1 ----------------
      stepc("bnc0", 3'b010, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      stepc("bnc1", 3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      stepc("bnc2", 3'b010, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      stepc("bnc3", 3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      for (int i = 0; i < 5; i++) stepc("bnc_hold", 3'b010, 2'd0, 1'b0, 3'b000, 3'b000, 2'd0);
      stepc("bnc_lat", 3'b010, 2'd0, 1'b0, 3'b010, 3'b010, 2'd1);
      stepc("bnc_post", 3'b010, 2'd0, 1'b0, 3'b010, 3'b000, 2'd1);

      // ---------------- collision: floor 0 set meets floor 0 clear ----------------
      // Floor 2 is accepted on the same edge and must latch independently.
      for (int i = 0; i < 5; i++) stepc("col_pre", 3'b111, 2'd0, 1'b0, 3'b010, 3'b000, 2'd1);
      stepc("col_edge", 3'b111, 2'd0, 1'b1, 3'b110, 3'b100, 2'd2);
      for (int i = 0; i < 5; i++) stepc("col_hold", 3'b111, 2'd0, 1'b0, 3'b110, 3'b000, 2'd2);
      for (int i = 0; i < 7; i++) stepc("col_rel", 3'b110, 2'd0, 1'b0, 3'b110, 3'b000, 2'd2);
      for (int i = 0; i < 5; i++) stepc("col_rep", 3'b111, 2'd0, 1'b0, 3'b110, 3'b000, 2'd2);
      stepc("col_relat", 3'b111, 2'd0, 1'b0, 3'b111, 3'b001, 2'd3);
      stepc("col_relat_post", 3'b111, 2'd0, 1'b0, 3'b111, 3'b000, 2'd3);

      // ---------------- duplicate presses on an already pending floor ----------------
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 7; i++) stepc("dup_rel", 3'b011, 2'd0, 1'b0, 3'b111, 3'b000, 2'd3);
         for (int i = 0; i < 7; i++) stepc("dup_prs", 3'b111, 2'd0, 1'b0, 3'b111, 3'b000, 2'd3);
      end

      // ---------------- hold floor 2 through its clear ----------------
      stepc("hold_clr", 3'b111, 2'd2, 1'b1, 3'b011, 3'b000, 2'd2);
      for (int i = 0; i < 8; i++) stepc("hold_on", 3'b111, 2'd0, 1'b0, 3'b011, 3'b000, 2'd2);
      for (int i = 0; i < 7; i++) stepc("hold_rel", 3'b011, 2'd0, 1'b0, 3'b011, 3'b000, 2'd2);
      for (int i = 0; i < 5; i++) stepc("hold_rep", 3'b111, 2'd0, 1'b0, 3'b011, 3'b000, 2'd2);
      stepc("hold_relat", 3'b111, 2'd0, 1'b0, 3'b111, 3'b100, 2'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_elevator_request_latch
`default_nettype wire
